// File: rtl/uart.sv
// uart: byte-wide 8N1 serial transceiver with a programmable bit-period divisor,
// a one-byte TX holding register, a one-byte RX buffer with sticky error flags
// and a single level interrupt.
//
// Bus handshake: an access is a single cycle with bus_cyc=1. bus_we=1 marks a
// write, which takes effect on that edge. Every access, read or write, loads
// data_out with the addressed register value on that edge, so read data is
// valid the following cycle. There is no wait state and no back-pressure.
module uart (
    input  logic       wb_clk_i,
    input  logic       rst_n,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       bus_cyc,
    input  logic       bus_we,
    output logic       TXD,
    input  logic       RXD,
    output logic       irq,
    output logic [1:0] o_dbg_tx_state,
    output logic [1:0] o_dbg_rx_state
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} state_t;

    logic [15:0] r_div;
    logic [2:0]  r_ctrl;
    logic [7:0]  r_data_out;
    logic [7:0]  r_tx_hold, r_tx_shift, w_tx_shift_nx;
    logic        r_tx_full, w_tx_load;
    state_t      r_tx_state, w_tx_state_nx;
    logic [15:0] r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]  r_tx_bit, w_tx_bit_nx;
    logic        r_sync1, r_sync2, r_rx_prev;
    state_t      r_rx_state, w_rx_state_nx;
    logic [15:0] r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]  r_rx_bit, w_rx_bit_nx;
    logic [7:0]  r_rx_shift, w_rx_shift_nx, r_rx_buf;
    logic        r_rx_valid, r_ovr, r_ferr;
    logic        w_rx_done, w_rx_stop_ok, w_store;
    logic [15:0] w_div_eff, w_half_m1;
    logic        w_wr_data, w_rd_data, w_wr_stat, w_wr, w_tx_busy, w_txd;
    logic [7:0]  w_rd_mux;

    // Period-1 is max(DIV,3); the half-period reload is P/2-1 with P = div_eff+1.
    assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;
    assign w_half_m1 = {1'b0, w_div_eff[15:1]} + {15'd0, w_div_eff[0]} - 16'd1;

    assign w_wr      = bus_cyc & bus_we;
    assign w_wr_data = w_wr & (addr == 4'd0);
    assign w_wr_stat = w_wr & (addr == 4'd1);
    assign w_rd_data = bus_cyc & ~bus_we & (addr == 4'd0);
    assign w_tx_busy = (r_tx_state != ST_IDLE);

    // Serial line is decoded from TX state so reset forces it high asynchronously.
    assign w_txd = (r_tx_state == ST_START) ? 1'b0 :
                   (r_tx_state == ST_DATA)  ? r_tx_shift[0] : 1'b1;
    assign TXD            = w_txd;
    assign data_out       = r_data_out;
    assign irq            = (r_ctrl[0] & r_rx_valid) | (r_ctrl[1] & ~r_tx_full);
    assign o_dbg_tx_state = r_tx_state;
    assign o_dbg_rx_state = r_rx_state;

    // TX next-state: counters reload with the current divisor only at bit boundaries.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_tx_load     = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                if (r_tx_full) begin
                    w_tx_load     = 1'b1;
                    w_tx_shift_nx = r_tx_hold;
                    w_tx_cnt_nx   = w_div_eff;
                    w_tx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_state_nx = ST_DATA;
                    w_tx_cnt_nx   = w_div_eff;
                    w_tx_bit_nx   = 3'd0;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_cnt_nx   = w_div_eff;
                    w_tx_shift_nx = {1'b1, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_nx = ST_STOP;
                    else                  w_tx_bit_nx   = r_tx_bit + 3'd1;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == 16'd0) begin
                    // A waiting byte starts its frame straight away, no idle bit between.
                    if (r_tx_full) begin
                        w_tx_load     = 1'b1;
                        w_tx_shift_nx = r_tx_hold;
                        w_tx_cnt_nx   = w_div_eff;
                        w_tx_state_nx = ST_START;
                    end else begin
                        w_tx_state_nx = ST_IDLE;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt - 16'd1;
                end
            end
            default: w_tx_state_nx = ST_IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'hFF;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
        end
    end

    // RX next-state: start edge, mid-start check, eight data samples, one stop sample.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_done     = 1'b0;
        w_rx_stop_ok  = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_sync2) begin
                    w_rx_state_nx = ST_START;
                    w_rx_cnt_nx   = w_half_m1;
                end
            end
            ST_START: begin
                if (r_rx_cnt == 16'd0) begin
                    if (r_sync2) begin
                        w_rx_state_nx = ST_IDLE;
                    end else begin
                        w_rx_state_nx = ST_DATA;
                        w_rx_cnt_nx   = w_div_eff;
                        w_rx_bit_nx   = 3'd0;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == 16'd0) begin
                    w_rx_shift_nx = {r_sync2, r_rx_shift[7:1]};
                    w_rx_cnt_nx   = w_div_eff;
                    if (r_rx_bit == 3'd7) w_rx_state_nx = ST_STOP;
                    else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == 16'd0) begin
                    w_rx_done     = 1'b1;
                    w_rx_stop_ok  = r_sync2;
                    w_rx_state_nx = ST_IDLE;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt - 16'd1;
                end
            end
            default: w_rx_state_nx = ST_IDLE;
        endcase
    end

    // RX synchronizer (loopback selects TXD) and RX state register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_sync1    <= r_ctrl[2] ? w_txd : RXD;
            r_sync2    <= r_sync1;
            r_rx_prev  <= r_sync2;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    assign w_store = w_rx_done & w_rx_stop_ok;

    // Read mux for the registered data_out.
    always_comb begin
        w_rd_mux = 8'hAA;
        case (addr)
            4'd0:    w_rd_mux = r_rx_buf;
            4'd1:    w_rd_mux = {3'b000, r_ferr, r_ovr, w_tx_busy, ~r_tx_full, r_rx_valid};
            4'd2:    w_rd_mux = r_div[7:0];
            4'd3:    w_rd_mux = r_div[15:8];
            4'd4:    w_rd_mux = {5'b00000, r_ctrl};
            default: w_rd_mux = 8'hAA;
        endcase
    end

    // Bus-visible registers: config, TX holding, RX buffer and sticky flags.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= 16'd433;
            r_ctrl     <= 3'd0;
            r_data_out <= 8'h00;
            r_tx_hold  <= 8'h00;
            r_tx_full  <= 1'b0;
            r_rx_buf   <= 8'h00;
            r_rx_valid <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (bus_cyc) r_data_out <= w_rd_mux;
            if (w_wr && addr == 4'd2) r_div[7:0]  <= data_in;
            if (w_wr && addr == 4'd3) r_div[15:8] <= data_in;
            if (w_wr && addr == 4'd4) r_ctrl      <= data_in[2:0];
            // A write into a full holding register is silently dropped.
            if (w_tx_load) begin
                r_tx_full <= 1'b0;
            end else if (w_wr_data && !r_tx_full) begin
                r_tx_hold <= data_in;
                r_tx_full <= 1'b1;
            end
            // A read in the same cycle frees the buffer for the incoming byte.
            if (w_store) begin
                if (!r_rx_valid || w_rd_data) begin
                    r_rx_buf   <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
            if (w_store && r_rx_valid && !w_rd_data) r_ovr <= 1'b1;
            else if (w_wr_stat && data_in[3])        r_ovr <= 1'b0;
            if (w_rx_done && !w_rx_stop_ok)          r_ferr <= 1'b1;
            else if (w_wr_stat && data_in[4])        r_ferr <= 1'b0;
        end
    end
endmodule

// File: doc/uart.md
# uart

Byte-wide 8N1 serial transceiver on the peripheral bus, sitting directly upstream and downstream of the GPIO block. Its TXD output feeds the GPIO PA1 special function. Its RXD input is the GPIO-conditioned PA2 line, which idles high when PA2 is not in special mode. It has a programmable 16-bit bit-period divisor, a one-byte TX holding register, a one-byte RX buffer with sticky error flags, and one level interrupt.

## Interface
- No parameters.
- wb_clk_i  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  4  register select.
- data_in  in  8  write data.
- data_out  out  8  registered read data; valid the cycle after a bus_cyc cycle.
- bus_cyc  in  1  access strobe, one cycle per access.
- bus_we  in  1  write qualifier for bus_cyc.
- TXD  out  1  serial transmit; idles high.
- RXD  in  1  serial receive, asynchronous to wb_clk_i.
- irq  out  1  level interrupt.

## Operation
- Register map. On every bus_cyc cycle, data_out is loaded with the addressed register value.
  - 0 DATA: a write loads the TX holding register. A read returns the RX buffer and clears rx_valid.
  - 1 STATUS: {3'b0, ferr, ovr, tx_busy, tx_empty, rx_valid}. Writing 1 to bit 3 clears ovr; writing 1 to bit 4 clears ferr. Other written bits are ignored.
  - 2 DIVL / 3 DIVH: divisor DIV[15:0]; reset value 16'd433.
  - 4 CTRL: bit0 rxie, bit1 txie, bit2 loop; bits 7:3 read 0.
  - 5-15: reads 8'hAA; writes ignored.
- Bit period P = max(DIV,3)+1 clocks. A new DIV takes effect at the next bit-counter reload, not mid-bit.
- TX holding register: a DATA write while tx_empty=0 is dropped, with no flag. tx_empty=1 means the holding register is free.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the holding register is full, move it to the shift register, set tx_empty=1, enter START.
  - START: TXD=0 for P clocks.
  - DATA: 8 bits LSB first, P clocks each.
  - STOP: TXD=1 for P clocks, then IDLE.
  - tx_busy=1 in every state except IDLE.
  - Back-to-back: if the holding register is full at the end of STOP, the next START begins on the following cycle with no extra idle bit time.
- RX input path: RXD passes through a 2-flop synchronizer (reset value 1). When loop=1, the synchronizer input is TXD instead of RXD.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 1->0 transition enters START.
  - START: wait P/2 clocks (integer division). If the line is high at that point, it is a false start: return to IDLE.
  - DATA: sample 8 bits at P-clock intervals, LSB first.
  - STOP: sample once after P clocks.
    - Stop bit high: store the byte.
    - Stop bit low: set ferr, discard the byte.
    - Either way, return to IDLE.
- Store rules:
  - If rx_valid=0: the byte goes to the buffer and rx_valid is set.
  - If rx_valid=1: set ovr, keep the old byte, drop the new one.
  - Store and a DATA read in the same cycle: the read returns the old byte, the new byte is stored, rx_valid stays 1, ovr is not set.
- irq = (rxie & rx_valid) | (txie & tx_empty), combinational from registers.
- Break condition (line held low): RX samples all zeros and sets ferr. No new frame starts until a fresh 1->0 edge.

## Timing
- Reset values:
  - TXD=1, irq=0, data_out=8'h00.
  - rx_valid=0, tx_empty=1, tx_busy=0, ovr=0, ferr=0.
  - CTRL=0, DIV=433, both FSMs in IDLE.
  - Reset asserted mid-frame aborts immediately; TXD returns high asynchronously.
- Read latency: 1 cycle. Write takes effect on the bus_cyc edge.
- TX latency: DATA write sampled at edge N with TX idle:
  - edge N+1: FSM loads the byte and enters START; tx_empty returns to 1.
  - from edge N+1: TXD low for P clocks.
  - Whole frame: 10·P clocks.
- RX latency: rx_valid rises 2 (sync) + P/2 + 9·P clocks after the line's falling edge, ±1 clock.
- Status flags update on the same edge as the event that sets them.
- A clear of ovr/ferr that coincides with a new set: the set wins.

## Test plan
- Reset, then read each register: DATA 00, STATUS 8'h02, DIVL 8'hB1, DIVH 8'h01, CTRL 00, addr 9 AA.
- DIV=3 (P=4), write 8'hA5: TXD low at N+1 for 4 clocks, then bits 1,0,1,0,0,1,0,1, then a high stop bit; frame is 40 clocks; tx_busy high for exactly 40 clocks.
- DIV=3, loop=1, write 8'h3C then 8'hC3 back-to-back: the second write is accepted only after tx_empty=1. Read DATA → 3C; after the second frame → C3; ovr=0.
- DIV=7, drive two RX frames 8'h11 and 8'h22 without reading: rx_valid=1, DATA reads 11, ovr=1. Write STATUS 8'h08 → ovr=0.
- RX frame with stop bit low: ferr=1, rx_valid=0. A 2-clock low glitch on RXD: no frame and no flags.
- rxie=1: irq rises with rx_valid and falls the cycle after the DATA read. txie=1 with idle TX: irq=1 immediately. Assert rst_n low mid-frame: TXD=1 at once and all flags at reset values.
